// File: rtl/mc_eject_buf.sv
// mc_eject_buf: local ejection FIFO for the multicast bufferless router.
// Each cycle it accepts up to NUM_IN eject requests, lowest lane first,
// limited by the free slots implied by the registered count. It drains one
// entry per cycle to the PE over valid/ready. Refused lanes stay in the
// network as deflected flits, so this block never stalls the router.

// Per-lane grant and slot select. A lane is granted when the requests ahead
// of it have not already used up the free slots. Because grants are
// contiguous in request order, the request prefix count is also the write
// offset of this lane.
module mc_eject_lane #(
    parameter int CNT_W = 4,
    parameter int PTR_W = 3
) (
    input  logic             req,
    input  logic             blocked,
    input  logic [CNT_W-1:0] pre_cnt,
    input  logic [CNT_W-1:0] free,
    input  logic [PTR_W-1:0] wr_ptr,
    output logic             grant,
    output logic [PTR_W-1:0] slot
);

    // Grant and slot are pure combinational functions of the lane inputs.
    always_comb begin
        grant = req && !blocked && (pre_cnt < free);
        slot  = wr_ptr + PTR_W'(pre_cnt);
    end

endmodule

module mc_eject_buf #(
    parameter int NUM_IN = 4,
    parameter int FLIT_W = 128,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        ejReq,
    input  logic [NUM_IN*FLIT_W-1:0] ejFlit,
    output logic [NUM_IN-1:0]        ejGrant,
    output logic                     peValid,
    output logic [FLIT_W-1:0]        peFlit,
    input  logic                     peReady,
    output logic [PTR_W:0]           occupancy
);

    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0]             mem [DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              count;
    logic [CNT_W-1:0]              free;
    logic [NUM_IN-1:0][CNT_W-1:0]  pre;
    logic [NUM_IN-1:0][PTR_W-1:0]  slot;
    logic [CNT_W-1:0]              n_grant;
    logic                          pop;

    // Free slots come from the registered count only, so a pop in the same
    // cycle never creates room and peReady stays out of the grant path.
    always_comb begin
        free = CNT_W'(DEPTH) - count;
    end

    // Exclusive prefix count of requests: number of requesting lanes below i.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pre[i] = acc;
            acc    = acc + CNT_W'(ejReq[i]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_lane
            mc_eject_lane #(
                .CNT_W (CNT_W),
                .PTR_W (PTR_W)
            ) u_lane (
                .req     (ejReq[g]),
                .blocked (reset),
                .pre_cnt (pre[g]),
                .free    (free),
                .wr_ptr  (wr_ptr),
                .grant   (ejGrant[g]),
                .slot    (slot[g])
            );
        end
    endgenerate

    // Number of lanes accepted this cycle.
    always_comb begin
        n_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            n_grant = n_grant + CNT_W'(ejGrant[i]);
        end
    end

    // Read side: head entry is exposed only when something is queued.
    always_comb begin
        peValid   = (count != '0);
        peFlit    = peValid ? mem[rd_ptr] : '0;
        pop       = peValid && peReady;
        occupancy = count;
    end

    // Flit storage; granted lanes hit distinct consecutive slots, so the
    // writes never collide. Contents are not reset, only the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (ejGrant[i]) begin
                mem[slot[i]] <= ejFlit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // Pointer and count update; reset discards every queued entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_grant);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_grant - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_mc_eject_buf.sv
// Directed bench for mc_eject_buf with hand-computed expectations.
module tb_mc_eject_buf;

    localparam int NUM_IN = 4;
    localparam int FLIT_W = 128;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_IN-1:0]        ejReq;
    logic [NUM_IN*FLIT_W-1:0] ejFlit;
    logic [NUM_IN-1:0]        ejGrant;
    logic                     peValid;
    logic [FLIT_W-1:0]        peFlit;
    logic                     peReady;
    logic [PTR_W:0]           occupancy;

    int n_vec  = 0;
    int n_fail = 0;
    logic [FLIT_W-1:0] expq [$];

    mc_eject_buf #(
        .NUM_IN (NUM_IN),
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ejReq     (ejReq),
        .ejFlit    (ejFlit),
        .ejGrant   (ejGrant),
        .peValid   (peValid),
        .peFlit    (peFlit),
        .peReady   (peReady),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] mk(input int tag);
        logic [31:0] t;
        t = 32'(tag);
        return {t ^ 32'hA5A5_0000, t, ~t, t};
    endfunction

    task automatic chk(input string tag, input logic [FLIT_W-1:0] obs,
                       input logic [FLIT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then land 1 ns after it (away from the edge).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [FLIT_W-1:0] f);
        ejFlit[i*FLIT_W +: FLIT_W] = f;
    endtask

    // Drain the expected queue with peReady high, checking order.
    task automatic drain(input string tag);
        peReady = 1'b1;
        ejReq   = '0;
        #1;
        while (expq.size() != 0) begin
            chk({tag, "_valid"}, FLIT_W'(peValid), FLIT_W'(1));
            chk({tag, "_flit"}, peFlit, expq.pop_front());
            tick();
        end
        peReady = 1'b0;
        #1;
        chk({tag, "_empty"}, FLIT_W'(occupancy), FLIT_W'(0));
    endtask

    initial begin
        int occ_m;
        int tag;
        int n;
        reset   = 1'b1;
        ejReq   = '1;
        ejFlit  = '0;
        peReady = 1'b1;
        #2;
        // reset state, with all lanes requesting
        chk("rst_grant", FLIT_W'(ejGrant), FLIT_W'(0));
        chk("rst_valid", FLIT_W'(peValid), FLIT_W'(0));
        chk("rst_occ", FLIT_W'(occupancy), FLIT_W'(0));
        chk("rst_flit", peFlit, '0);
        ejReq   = '0;
        peReady = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // single request
        set_lane(0, mk(32'h100));
        ejReq = 4'b0001;
        #1;
        chk("single_grant", FLIT_W'(ejGrant), FLIT_W'(4'b0001));
        chk("single_nobypass", FLIT_W'(peValid), FLIT_W'(0));
        tick();
        ejReq = '0;
        #1;
        chk("single_valid", FLIT_W'(peValid), FLIT_W'(1));
        chk("single_flit", peFlit, mk(32'h100));
        chk("single_occ", FLIT_W'(occupancy), FLIT_W'(1));
        peReady = 1'b1;
        tick();
        peReady = 1'b0;
        #1;
        chk("single_occ0", FLIT_W'(occupancy), FLIT_W'(0));
        chk("single_valid0", FLIT_W'(peValid), FLIT_W'(0));
        // peReady while empty has no effect
        peReady = 1'b1;
        tick();
        chk("empty_ready_occ", FLIT_W'(occupancy), FLIT_W'(0));
        peReady = 1'b0;

        // burst ordering
        for (int i = 0; i < 4; i++) set_lane(i, mk(32'h200 + i));
        ejReq = 4'b1111;
        #1;
        chk("burst_grant", FLIT_W'(ejGrant), FLIT_W'(4'b1111));
        for (int i = 0; i < 4; i++) expq.push_back(mk(32'h200 + i));
        tick();
        ejReq = '0;
        #1;
        chk("burst_occ", FLIT_W'(occupancy), FLIT_W'(4));
        drain("burst");

        // partial grant: fill to 6, then 1110 fits only lanes 1 and 2
        for (int i = 0; i < 4; i++) set_lane(i, mk(32'h300 + i));
        ejReq = 4'b1111;
        for (int i = 0; i < 4; i++) expq.push_back(mk(32'h300 + i));
        tick();
        ejReq = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            set_lane(i, mk(32'h310 + i));
            expq.push_back(mk(32'h310 + i));
        end
        tick();
        ejReq = '0;
        #1;
        chk("part_occ6", FLIT_W'(occupancy), FLIT_W'(6));
        for (int i = 0; i < 4; i++) set_lane(i, mk(32'h320 + i));
        ejReq = 4'b1110;
        #1;
        chk("part_grant", FLIT_W'(ejGrant), FLIT_W'(4'b0110));
        expq.push_back(mk(32'h321));
        expq.push_back(mk(32'h322));
        tick();
        ejReq   = 4'b1111;
        peReady = 1'b1;
        #1;
        chk("part_occ8", FLIT_W'(occupancy), FLIT_W'(8));
        chk("full_grant", FLIT_W'(ejGrant), FLIT_W'(0));
        chk("full_head", peFlit, expq.pop_front());
        tick();
        ejReq   = '0;
        peReady = 1'b0;
        #1;
        chk("full_occ7", FLIT_W'(occupancy), FLIT_W'(7));
        drain("part");

        // backpressure with 3 entries
        for (int i = 0; i < 3; i++) begin
            set_lane(i, mk(32'h400 + i));
            expq.push_back(mk(32'h400 + i));
        end
        ejReq = 4'b0111;
        tick();
        ejReq = '0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_flit", peFlit, mk(32'h400));
            chk("bp_occ", FLIT_W'(occupancy), FLIT_W'(3));
            tick();
        end
        drain("bp");

        // wrap-around: 3 requests per cycle, 1 pop per cycle
        occ_m   = 0;
        tag     = 32'h500;
        peReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) set_lane(i, mk(tag + i));
            ejReq = 4'b0111;
            #1;
            n = DEPTH - occ_m;
            if (n > 3) n = 3;
            chk("wrap_grant", FLIT_W'(ejGrant), FLIT_W'((1 << n) - 1));
            chk("wrap_occ", FLIT_W'(occupancy), FLIT_W'(occ_m));
            if (occ_m != 0) chk("wrap_flit", peFlit, expq.pop_front());
            for (int i = 0; i < n; i++) expq.push_back(mk(tag + i));
            occ_m = occ_m + n - ((occ_m != 0) ? 1 : 0);
            tag   = tag + 16;
            tick();
        end
        drain("wrap");

        // reset mid-operation with 5 entries queued
        for (int i = 0; i < 4; i++) set_lane(i, mk(32'h600 + i));
        ejReq = 4'b1111;
        tick();
        ejReq = 4'b0001;
        tick();
        ejReq = 4'b1111;
        #1;
        chk("mid_occ5", FLIT_W'(occupancy), FLIT_W'(5));
        #1;
        reset = 1'b1;
        #1;
        chk("mid_valid", FLIT_W'(peValid), FLIT_W'(0));
        chk("mid_occ", FLIT_W'(occupancy), FLIT_W'(0));
        chk("mid_grant", FLIT_W'(ejGrant), FLIT_W'(0));
        chk("mid_flit", peFlit, '0);
        #1;
        reset = 1'b0;
        ejReq = 4'b0100;
        set_lane(2, mk(32'h777));
        #1;
        chk("post_grant", FLIT_W'(ejGrant), FLIT_W'(4'b0100));
        tick();
        ejReq = '0;
        #1;
        chk("post_occ", FLIT_W'(occupancy), FLIT_W'(1));
        expq.push_back(mk(32'h777));
        drain("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
